// File: rtl/entropy_collector_pkg.sv
// Shared TRNG parameters: word width, default block sizing and collector FSM encodings.
// The mixer sizes its block input from the same NUM_WORDS default.
package entropy_collector_pkg;

  localparam int WORD_W                 = 32;
  localparam int NUM_WORDS_DEFAULT      = 16;
  localparam int TIMEOUT_CYCLES_DEFAULT = 4096;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    ACK     = 2'd2,
    FULL    = 2'd3
  } col_state_t;

endpackage

// File: rtl/entropy_collector.sv
// Packs NUM_WORDS syn/ack entropy words into one block; at most one word per 2 cycles.
// A full block is held with block_valid until block_ack; no words are acked meanwhile.
module entropy_collector
  import entropy_collector_pkg::*;
#(
  parameter int NUM_WORDS      = NUM_WORDS_DEFAULT,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        enable,
  input  logic                        entropy_enabled,
  input  logic                        entropy_syn,
  input  logic [WORD_W-1:0]           entropy_data,
  output logic                        entropy_ack,
  output logic                        block_valid,
  output logic [NUM_WORDS*WORD_W-1:0] block_data,
  input  logic                        block_ack,
  output logic [7:0]                  word_count,
  output logic                        stall
);

  localparam int              TO_W       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0]      LAST_COUNT = 8'(NUM_WORDS);
  localparam logic [TO_W-1:0] TO_LIMIT   = TO_W'(TIMEOUT_CYCLES);

  col_state_t      state;
  col_state_t      state_nxt;
  logic            en_ok;
  logic            capture;
  logic            clr_count;
  logic            count_idle;
  logic [TO_W-1:0] to_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    en_ok      = enable && entropy_enabled;
    state_nxt  = state;
    capture    = 1'b0;
    clr_count  = 1'b0;
    count_idle = 1'b0;
    if (!en_ok) begin
      // Disable wins over a word presented in the same cycle.
      state_nxt = IDLE;
      clr_count = 1'b1;
    end else begin
      unique case (state)
        IDLE: state_nxt = COLLECT;
        COLLECT: begin
          if (entropy_syn) begin
            capture   = 1'b1;
            state_nxt = ACK;
          end else begin
            count_idle = 1'b1;
          end
        end
        ACK: state_nxt = (word_count == LAST_COUNT) ? FULL : COLLECT;
        FULL: begin
          if (block_ack) begin
            state_nxt = COLLECT;
            clr_count = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
    entropy_ack = (state == ACK) && en_ok;
    block_valid = (state == FULL);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word_count <= '0;
      block_data <= '0;
      to_cnt     <= '0;
      stall      <= 1'b0;
    end else begin
      if (clr_count) begin
        word_count <= '0;
      end else if (capture) begin
        word_count <= word_count + 8'd1;
      end

      // First word lands in the most-significant slot.
      for (int i = 0; i < NUM_WORDS; i++) begin
        if (capture && word_count == 8'(i)) begin
          block_data[(NUM_WORDS-1-i)*WORD_W +: WORD_W] <= entropy_data;
        end
      end

      if (count_idle) begin
        if (to_cnt != TO_LIMIT) begin
          to_cnt <= to_cnt + TO_W'(1);
        end
      end else begin
        to_cnt <= '0;
      end

      if (!enable) begin
        stall <= 1'b0;
      end else if (count_idle && to_cnt == TO_LIMIT - TO_W'(1)) begin
        stall <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_entropy_collector.sv
// Directed bench for entropy_collector: fake source, block scoreboard, timeout and reset cases.
module tb_entropy_collector;
  import entropy_collector_pkg::*;

  localparam int NW = 16;
  localparam int TO = 16;
  localparam int BW = NW * 32;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          enable;
  logic          entropy_enabled;
  logic          entropy_syn;
  logic [31:0]   entropy_data;
  logic          entropy_ack;
  logic          block_valid;
  logic [BW-1:0] block_data;
  logic          block_ack;
  logic [7:0]    word_count;
  logic          stall;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int ack_n  = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  entropy_collector #(
    .NUM_WORDS      (NW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .enable          (enable),
    .entropy_enabled (entropy_enabled),
    .entropy_syn     (entropy_syn),
    .entropy_data    (entropy_data),
    .entropy_ack     (entropy_ack),
    .block_valid     (block_valid),
    .block_data      (block_data),
    .block_ack       (block_ack),
    .word_count      (word_count),
    .stall           (stall)
  );

  always @(negedge clk) begin
    cyc++;
    if (entropy_ack) ack_n++;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_word(input logic [31:0] w, output int ack_cyc);
    bit got;
    got          = 1'b0;
    ack_cyc      = -1;
    entropy_data = w;
    entropy_syn  = 1'b1;
    exp_q.push_back(w);
    for (int i = 0; i < 200 && !got; i++) begin
      tick();
      if (entropy_ack) begin
        got     = 1'b1;
        ack_cyc = cyc;
      end
    end
    if (!got) chk("ack_wait", BW'(entropy_ack), BW'(1));
  endtask

  task automatic check_block(input string tag);
    logic [BW-1:0] expv;
    expv = '0;
    for (int i = 0; i < 50 && !block_valid; i++) tick();
    chk({tag, "_valid"}, BW'(block_valid), BW'(1));
    for (int i = 0; i < NW; i++) begin
      if (exp_q.size() > 0) expv[BW-1-32*i -: 32] = exp_q.pop_front();
    end
    chk({tag, "_data"}, block_data, expv);
  endtask

  task automatic ack_block();
    block_ack = 1'b1;
    tick();
    block_ack = 1'b0;
  endtask

  initial begin
    int a0;
    int a1;
    int a_prev;
    int bad_gap;
    int n0;
    logic [BW-1:0] t2_blk;

    reset_n         = 1'b0;
    enable          = 1'b0;
    entropy_enabled = 1'b0;
    entropy_syn     = 1'b0;
    entropy_data    = '0;
    block_ack       = 1'b0;
    a0              = 0;
    a_prev          = 0;
    repeat (3) tick();
    chk("rst_ack",   BW'(entropy_ack), BW'(0));
    chk("rst_valid", BW'(block_valid), BW'(0));
    chk("rst_data",  block_data,       BW'(0));
    chk("rst_wc",    BW'(word_count),  BW'(0));
    chk("rst_stall", BW'(stall),       BW'(0));
    reset_n = 1'b1;
    tick();

    // Constant-data source with syn held high.
    enable          = 1'b1;
    entropy_enabled = 1'b1;
    bad_gap         = 0;
    n0              = ack_n;
    for (int i = 0; i < NW; i++) begin
      send_word(32'h01020304, a1);
      if (i == 0) a0 = a1;
      else if (a1 - a_prev != 2) bad_gap++;
      a_prev = a1;
    end
    chk("t1_ack_count", BW'(ack_n - n0), BW'(NW));
    chk("t1_ack_gap",   BW'(bad_gap),    BW'(0));
    chk("t1_span",      BW'(a_prev - a0), BW'(30));
    chk("t1_valid_early", BW'(block_valid), BW'(0));
    tick();
    chk("t1_valid_rise", BW'(block_valid), BW'(1));
    check_block("t1");
    ack_block();
    chk("t1_wc_clear",  BW'(word_count),  BW'(0));
    chk("t1_valid_drop", BW'(block_valid), BW'(0));

    // Incrementing words, word_count progression.
    t2_blk = '0;
    for (int i = 0; i < NW; i++) begin
      t2_blk[BW-1-32*i -: 32] = 32'(i);
      send_word(32'(i), a1);
      chk("t2_word_count", BW'(word_count), BW'(i + 1));
    end
    check_block("t2");
    chk("t2_msw",   BW'(block_data[BW-1 -: 32]), BW'(0));
    chk("t2_lsw",   BW'(block_data[31:0]),       BW'(32'hF));
    chk("t2_wc_16", BW'(word_count),             BW'(NW));

    // Mixer stalls the block for 100 cycles while the source keeps syn high.
    entropy_data = 32'hAAAA_0000;
    entropy_syn  = 1'b1;
    n0           = ack_n;
    repeat (100) tick();
    chk("t3_no_ack",      BW'(ack_n - n0),  BW'(0));
    chk("t3_valid_held",  BW'(block_valid), BW'(1));
    chk("t3_data_stable", block_data,       t2_blk);
    ack_block();
    chk("t3_wc_clear",   BW'(word_count),  BW'(0));
    chk("t3_valid_drop", BW'(block_valid), BW'(0));
    for (int i = 0; i < 7; i++) send_word(32'hAAAA_0000 + 32'(i), a1);
    chk("t3_wc_7", BW'(word_count), BW'(7));

    // Disable in the same cycle the 8th word is presented.
    entropy_data = 32'hAAAA_0007;
    tick();
    n0     = ack_n;
    enable = 1'b0;
    tick();
    chk("t4_idle",  BW'(dut.state),  BW'(IDLE));
    chk("t4_wc_0",  BW'(word_count), BW'(0));
    repeat (5) tick();
    chk("t4_no_ack", BW'(ack_n - n0), BW'(0));
    exp_q.delete();
    enable = 1'b1;
    for (int i = 0; i < NW; i++) send_word(32'hC0DE_0000 + 32'(i), a1);
    check_block("t4");
    chk("t4_msw", BW'(block_data[BW-1 -: 32]), BW'(32'hC0DE_0000));

    // Source goes quiet: stall after TO idle cycles in COLLECT.
    entropy_syn = 1'b0;
    ack_block();
    repeat (TO - 1) tick();
    chk("t5_stall_low",  BW'(stall), BW'(0));
    tick();
    chk("t5_stall_rise", BW'(stall), BW'(1));
    send_word(32'hDEAD_0000, a1);
    send_word(32'hDEAD_0001, a1);
    chk("t5_stall_sticky", BW'(stall), BW'(1));
    chk("t5_wc_2", BW'(word_count), BW'(2));
    exp_q.delete();
    enable      = 1'b0;
    entropy_syn = 1'b0;
    tick();
    chk("t5_stall_clear", BW'(stall), BW'(0));

    // Asynchronous reset while an ack is on the wire.
    enable       = 1'b1;
    entropy_syn  = 1'b1;
    entropy_data = 32'h5A5A_5A5A;
    for (int i = 0; i < 20 && !entropy_ack; i++) tick();
    chk("t6_in_ack", BW'(entropy_ack), BW'(1));
    reset_n = 1'b0;
    #1;
    chk("t6_rst_ack",   BW'(entropy_ack), BW'(0));
    chk("t6_rst_valid", BW'(block_valid), BW'(0));
    chk("t6_rst_wc",    BW'(word_count),  BW'(0));
    repeat (2) tick();
    reset_n = 1'b1;
    exp_q.delete();
    for (int i = 0; i < NW; i++) send_word(32'h6000_0000 + 32'(i), a1);
    check_block("t6");
    chk("t6_msw", BW'(block_data[BW-1 -: 32]), BW'(32'h6000_0000));
    chk("t6_lsw", BW'(block_data[31:0]),       BW'(32'h6000_000F));
    ack_block();
    chk("t6_wc_clear", BW'(word_count), BW'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
